// File: rtl/aesl_deadlock_pkg.sv
// Shared types and helpers for the parametrised deadlock monitor.
// State encoding, default stall threshold and the sub-instance block reduction.
package aesl_deadlock_pkg;

  typedef enum logic [1:0] {
    DL_IDLE     = 2'd0,
    DL_SUSPECT  = 2'd1,
    DL_DEADLOCK = 2'd2
  } dl_state_t;

  localparam int DL_BLOCK_THRESH_DEF = 16;
  localparam int DL_MAX_SUB          = 32;

  // Every sub-instance idle-or-blocked and at least one blocked; 0 when none exist.
  function automatic logic dl_sub_blk(input logic [DL_MAX_SUB-1:0] idle,
                                      input logic [DL_MAX_SUB-1:0] blk,
                                      input int                    n);
    logic all_ok;
    logic any_blk;
    all_ok  = 1'b1;
    any_blk = 1'b0;
    for (int i = 0; i < DL_MAX_SUB; i++) begin
      if (i < n) begin
        all_ok  = all_ok & (idle[i] | blk[i]);
        any_blk = any_blk | blk[i];
      end
    end
    return (n > 0) && all_ok && any_blk;
  endfunction

endpackage

// File: rtl/aesl_stall_counter.sv
// Saturating consecutive-stall counter; o_hit flags that this increment
// lands exactly on THRESH.
module aesl_stall_counter #(
  parameter int THRESH = 16,
  parameter int CNT_W  = $clog2(THRESH + 1)
) (
  input  logic             i_clk,
  input  logic             i_srst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_hit
);

  localparam logic [CNT_W-1:0] HIT_PREV = CNT_W'(THRESH - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_sat;

  assign w_sat = &r_cnt;
  assign o_cnt = r_cnt;
  assign o_hit = i_inc && (r_cnt == HIT_PREV);

  // A cycle without increment is a gap and restarts the run from zero.
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_cnt <= '0;
    end else if (!i_inc) begin
      r_cnt <= '0;
    end else if (!w_sat) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/aesl_deadlock_monitor_param.sv
// Deadlock monitor for one HLS instance: escalates a persistent stall to a sticky flag.
// Optional macro DEADLOCK_MON_TRACE_EN adds a cycle counter and a report on deadlock.
module aesl_deadlock_monitor_param
  import aesl_deadlock_pkg::*;
#(
  parameter int                NUM_AXIS     = 4,
  parameter int                NUM_SUB      = 3,
  parameter logic [NUM_AXIS-1:0] AXIS_MASK  = 4'b0011,
  parameter int                BLOCK_THRESH = DL_BLOCK_THRESH_DEF,
  localparam int               CNT_W        = $clog2(BLOCK_THRESH + 1)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        clear,
  input  logic [NUM_AXIS-1:0]         axis_block_sigs,
  input  logic [NUM_SUB-1:0]          inst_idle_sigs,
  input  logic [NUM_SUB-1:0]          inst_block_sigs,
  output logic                        block,
  output logic                        deadlock,
  output logic [NUM_AXIS+NUM_SUB-1:0] block_src,
  output logic [CNT_W-1:0]            stall_cnt
);

  logic [NUM_AXIS-1:0]         w_axis_masked;
  logic [DL_MAX_SUB-1:0]       w_idle_ext;
  logic [DL_MAX_SUB-1:0]       w_blk_ext;
  logic                        w_axis_blk;
  logic                        w_sub_blk;
  logic                        w_raw;
  logic                        w_hit;
  logic                        w_set;
  logic [NUM_AXIS+NUM_SUB-1:0] w_src;

  dl_state_t                   r_state;
  logic                        r_block;
  logic                        r_deadlock;
  logic [NUM_AXIS+NUM_SUB-1:0] r_src;

  genvar gi;
  generate
    for (gi = 0; gi < DL_MAX_SUB; gi++) begin : g_sub_ext
      if (gi < NUM_SUB) begin : g_used
        assign w_idle_ext[gi] = inst_idle_sigs[gi];
        assign w_blk_ext[gi]  = inst_block_sigs[gi];
      end else begin : g_pad
        assign w_idle_ext[gi] = 1'b0;
        assign w_blk_ext[gi]  = 1'b0;
      end
    end
  endgenerate

  // Masking first keeps X on disabled axis bits from reaching any output.
  assign w_axis_masked = axis_block_sigs & AXIS_MASK;
  assign w_axis_blk    = |w_axis_masked;
  assign w_sub_blk     = dl_sub_blk(w_idle_ext, w_blk_ext, NUM_SUB);
  assign w_raw         = w_axis_blk | w_sub_blk;
  assign w_src         = {inst_block_sigs, w_axis_masked};
  assign w_set         = w_raw && w_hit && (r_state != DL_DEADLOCK);

  aesl_stall_counter #(
    .THRESH (BLOCK_THRESH),
    .CNT_W  (CNT_W)
  ) u_stall_counter (
    .i_clk  (clock),
    .i_srst (reset | clear),
    .i_inc  (w_raw),
    .o_cnt  (stall_cnt),
    .o_hit  (w_hit)
  );

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_state    <= DL_IDLE;
      r_block    <= 1'b0;
      r_deadlock <= 1'b0;
      r_src      <= '0;
    end else begin
      r_block <= w_raw;
      case (r_state)
        DL_IDLE, DL_SUSPECT: begin
          if (w_set) begin
            r_state    <= DL_DEADLOCK;
            r_deadlock <= 1'b1;
            r_src      <= w_src;
          end else if (w_raw) begin
            r_state <= DL_SUSPECT;
          end else begin
            r_state <= DL_IDLE;
          end
        end
        default: r_state <= DL_DEADLOCK;
      endcase
    end
  end

  assign block     = r_block;
  assign deadlock  = r_deadlock;
  assign block_src = r_src;

`ifdef DEADLOCK_MON_TRACE_EN
  logic [31:0] r_cycle;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cycle <= '0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
    end
    if (!reset && !clear && w_set) begin
      $display("%m: deadlock at cycle %0d block_src=%h", r_cycle, w_src);
    end
  end
`endif

endmodule

// File: tb/tb_aesl_deadlock_monitor_param.sv
// Self-checking bench for aesl_deadlock_monitor_param against a run-length reference model.
module tb_aesl_deadlock_monitor_param;

  localparam int          NA   = 4;
  localparam int          NS   = 3;
  localparam int          TH   = 16;
  localparam int          CW   = 5;
  localparam int          CMAX = 31;
  localparam logic [3:0]  MASK = 4'b0011;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic [3:0]  axis;
  logic [2:0]  idle;
  logic [2:0]  blk;
  logic        block;
  logic        deadlock;
  logic [6:0]  src;
  logic [CW-1:0] cnt;
  logic [13:0] dut_vec;

  int   n_checks = 0;
  int   n_fail   = 0;

  int          m_run   = 0;
  bit          m_dl    = 1'b0;
  bit          m_block = 1'b0;
  logic [6:0]  m_src   = '0;

  always #5 clk = ~clk;

  aesl_deadlock_monitor_param #(
    .NUM_AXIS     (NA),
    .NUM_SUB      (NS),
    .AXIS_MASK    (MASK),
    .BLOCK_THRESH (TH)
  ) dut (
    .clock           (clk),
    .reset           (reset),
    .clear           (clear),
    .axis_block_sigs (axis),
    .inst_idle_sigs  (idle),
    .inst_block_sigs (blk),
    .block           (block),
    .deadlock        (deadlock),
    .block_src       (src),
    .stall_cnt       (cnt)
  );

  assign dut_vec = {block, deadlock, src, cnt};

  // Raw stall as described: any enabled axis flag, or all subs idle/blocked with one blocked.
  function automatic bit ref_raw(input logic [3:0] a, input logic [2:0] i, input logic [2:0] b);
    logic [3:0] msk;
    bit axis_any, all_ok, any_b;
    msk = MASK;
    axis_any = 0; all_ok = 1; any_b = 0;
    for (int k = 0; k < NA; k++) if (msk[k] && a[k] === 1'b1) axis_any = 1;
    for (int k = 0; k < NS; k++) begin
      if (!(i[k] || b[k])) all_ok = 0;
      if (b[k]) any_b = 1;
    end
    return axis_any || (all_ok && any_b);
  endfunction

  function automatic logic [13:0] exp_vec();
    logic [CW-1:0] c;
    c = (m_run > CMAX) ? CW'(CMAX) : CW'(m_run);
    return {m_block, m_dl, m_src, c};
  endfunction

  // Apply one cycle of inputs, advance the model across the edge, settle 1 time unit.
  task automatic step(input logic [3:0] a, input logic [2:0] i, input logic [2:0] b,
                      input bit c, input bit r);
    bit raw;
    axis = a; idle = i; blk = b; clear = c; reset = r;
    @(posedge clk);
    if (r || c) begin
      m_run = 0; m_dl = 0; m_src = '0; m_block = 0;
    end else begin
      raw     = ref_raw(a, i, b);
      m_block = raw;
      m_run   = raw ? m_run + 1 : 0;
      if (!m_dl && m_run == TH) begin
        m_dl  = 1;
        m_src = {b, a & MASK};
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) step(4'b0, 3'b0, 3'b0, 0, 1);
    n_checks++;
    if (dut_vec !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", dut_vec, 14'd0);
    end
    $display("test_reset done");
  endtask

  task automatic test_masked();
    step(4'b0, 3'b0, 3'b0, 0, 1);
    for (int k = 0; k < 40; k++) begin
      step((k % 2) ? 4'b0100 : 4'b1100, 3'b0, 3'b0, 0, 0);
      n_checks++;
      if (dut_vec !== 14'd0) begin
        n_fail++;
        $display("FAIL masked_out cyc%0d: got %h expected %h", k, dut_vec, 14'd0);
      end
    end
    $display("test_masked done");
  endtask

  task automatic test_gap();
    step(4'b0, 3'b0, 3'b0, 0, 1);
    for (int seg = 0; seg < 2; seg++) begin
      for (int k = 0; k < 15; k++) step(4'b0001, 3'b0, 3'b0, 0, 0);
      n_checks++;
      if ({deadlock, cnt} !== {1'b0, 5'd15}) begin
        n_fail++;
        $display("FAIL gap_run%0d: got dl=%b cnt=%0d expected dl=0 cnt=15", seg, deadlock, cnt);
      end
      step(4'b0, 3'b0, 3'b0, 0, 0);
      n_checks++;
      if (dut_vec !== exp_vec() || cnt !== 5'd0) begin
        n_fail++;
        $display("FAIL gap_restart%0d: got %h expected %h", seg, dut_vec, exp_vec());
      end
    end
    $display("test_gap done");
  endtask

  task automatic test_axis_deadlock();
    step(4'b0, 3'b0, 3'b0, 0, 1);
    for (int k = 1; k <= 16; k++) begin
      step(4'b0010, 3'b0, 3'b0, 0, 0);
      n_checks++;
      if (deadlock !== (k == 16)) begin
        n_fail++;
        $display("FAIL axis_dl_edge k=%0d: got %b expected %b", k, deadlock, (k == 16));
      end
    end
    n_checks++;
    if ({src, cnt} !== {7'b0000010, 5'd16}) begin
      n_fail++;
      $display("FAIL axis_dl_src: got src=%b cnt=%0d expected src=0000010 cnt=16", src, cnt);
    end
    for (int k = 0; k < 3; k++) step(4'b0, 3'b0, 3'b0, 0, 0);
    n_checks++;
    if (dut_vec !== {1'b0, 1'b1, 7'b0000010, 5'd0}) begin
      n_fail++;
      $display("FAIL axis_dl_sticky: got %h expected %h", dut_vec, {1'b0, 1'b1, 7'b0000010, 5'd0});
    end
    $display("test_axis_deadlock done");
  endtask

  task automatic test_sub_deadlock();
    step(4'b0, 3'b0, 3'b0, 0, 1);
    for (int k = 0; k < 16; k++) step(4'b0, 3'b101, 3'b010, 0, 0);
    n_checks++;
    if ({deadlock, src} !== {1'b1, 7'b0100000}) begin
      n_fail++;
      $display("FAIL sub_dl: got dl=%b src=%b expected dl=1 src=0100000", deadlock, src);
    end
    step(4'b0, 3'b0, 3'b0, 0, 1);
    for (int k = 0; k < 20; k++) step(4'b0, 3'b001, 3'b010, 0, 0);
    n_checks++;
    if (dut_vec !== 14'd0) begin
      n_fail++;
      $display("FAIL sub_not_all_idle: got %h expected %h", dut_vec, 14'd0);
    end
    $display("test_sub_deadlock done");
  endtask

  task automatic test_saturation();
    step(4'b0, 3'b0, 3'b0, 0, 1);
    for (int k = 0; k < 40; k++) begin
      step(4'b0001, 3'b0, 3'b0, 0, 0);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL saturate k=%0d: got %h expected %h", k, dut_vec, exp_vec());
      end
    end
    n_checks++;
    if (cnt !== 5'd31) begin
      n_fail++;
      $display("FAIL saturate_final: got %0d expected 31", cnt);
    end
    $display("test_saturation done");
  endtask

  task automatic test_clear_reset();
    step(4'b0, 3'b0, 3'b0, 0, 1);
    for (int k = 0; k < 16; k++) step(4'b0001, 3'b0, 3'b0, 0, 0);
    step(4'b0001, 3'b0, 3'b0, 1, 0);
    n_checks++;
    if (dut_vec !== 14'd0) begin
      n_fail++;
      $display("FAIL clear: got %h expected %h", dut_vec, 14'd0);
    end
    for (int k = 0; k < 9; k++) step(4'b0001, 3'b0, 3'b0, 0, 0);
    n_checks++;
    if ({deadlock, cnt} !== {1'b0, 5'd9}) begin
      n_fail++;
      $display("FAIL suspect_cnt9: got dl=%b cnt=%0d expected dl=0 cnt=9", deadlock, cnt);
    end
    step(4'b0001, 3'b0, 3'b0, 0, 1);
    n_checks++;
    if (dut_vec !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_mid_suspect: got %h expected %h", dut_vec, 14'd0);
    end
    for (int k = 1; k <= 16; k++) begin
      step(4'b0001, 3'b0, 3'b0, 0, 0);
      n_checks++;
      if (deadlock !== (k == 16)) begin
        n_fail++;
        $display("FAIL restart_after_reset k=%0d: got %b expected %b", k, deadlock, (k == 16));
      end
    end
    $display("test_clear_reset done");
  endtask

  task automatic test_random();
    logic [3:0] a;
    logic [2:0] i, b;
    int len;
    step(4'b0, 3'b0, 3'b0, 0, 1);
    for (int seg = 0; seg < 60; seg++) begin
      len = $urandom_range(1, 24);
      a = 4'($urandom); i = 3'($urandom); b = 3'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        a = '0; b = '0;
      end
      for (int k = 0; k < len; k++) begin
        a[3:2] = 2'($urandom);
        if ($urandom_range(0, 99) == 0) step(a, i, b, 1, 0);
        else if ($urandom_range(0, 149) == 0) step(a, i, b, 0, 1);
        else step(a, i, b, 0, 0);
        n_checks++;
        if (dut_vec !== exp_vec()) begin
          n_fail++;
          $display("FAIL random seg%0d k%0d: got %h expected %h", seg, k, dut_vec, exp_vec());
        end
      end
    end
    $display("test_random done");
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; axis = '0; idle = '0; blk = '0;
    test_reset();
    test_masked();
    test_gap();
    test_axis_deadlock();
    test_sub_deadlock();
    test_saturation();
    test_clear_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
